shiftreg_controller: RTL and testbench
======================================

# shiftreg_controller

Parametrised successor to the lab's fixed 8-bit midpoint shift-register block. It conditions four raw board inputs (synchronise and debounce each input, then detect edges) and drives a WIDTH-bit shift register. The register supports parallel load, bidirectional serial shift and a saturating shift counter with a done flag. The block sits between the board buttons/switches and the display/serial output logic, and runs on the single 50 MHz system clock.

## Interface
- WIDTH, 8, shift register width (≥2)
- DEBOUNCE, 10, consecutive stable synchronised cycles required before a conditioned input changes (≥1)
- CNTW, $clog2(WIDTH+1), shift counter width (derived, not overridden)

- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state
- btn0  input  1  raw load request; conditioned rising edge loads parallelin
- switch0  input  1  raw serial data in; conditioned level is shifted in
- switch1  input  1  raw shift request; conditioned rising edge performs one shift
- dir  input  1  raw direction; conditioned 0 = shift toward MSB, 1 = toward LSB
- parallelin  input  WIDTH  value captured on load
- parallelout  output  WIDTH  shift register contents
- serialout  output  1  MSB when conditioned dir=0, LSB when conditioned dir=1
- shiftcount  output  CNTW  shifts since last load, saturates at WIDTH
- done  output  1  high when shiftcount == WIDTH

## Operation
- There is one conditioner per raw input (btn0, switch0, switch1, dir).
  - A 2-FF synchroniser feeds a debounce counter and the conditioned register `cond`.
  - When sync == cond: counter cleared to 0.
  - When sync != cond and counter < DEBOUNCE-1: counter increments.
  - When sync != cond and counter == DEBOUNCE-1: cond <= sync and counter <= 0. On the same edge a one-cycle posedge or negedge pulse is registered.
  - Any agreement before the count completes aborts the change. Glitches shorter than DEBOUNCE synchronised cycles are rejected.
- Shift register actions, evaluated each edge in priority order:
  1. btn0 posedge pulse: reg <= parallelin, shiftcount <= 0.
  2. switch1 posedge pulse with dir_cond=0: reg <= {reg[WIDTH-2:0], switch0_cond}, shiftcount saturating +1.
  3. switch1 posedge pulse with dir_cond=1: reg <= {switch0_cond, reg[WIDTH-1:1]}, shiftcount saturating +1.
  4. Otherwise: hold.
- Simultaneous load and shift pulses: load wins and the shift is dropped.
- Shift at shiftcount == WIDTH: the shift is performed, the count stays at WIDTH and done stays 1.
- Negedge pulses are generated but unused by the register (reserved for later use).
- serialout and done are combinational from registered state; all other outputs are registered.

## Timing
- Reset values: parallelout 0, serialout 0, shiftcount 0, done 0; all synchronisers, debounce counters, cond registers and pulses 0.
  - Reset asserted mid-debounce discards the partial count.
  - After reset deassertion a raw input held at 1 is treated as a fresh change: it passes through the full synchroniser and debounce path before it takes effect.
- Latency: a raw level first sampled at edge N appears in cond, with its pulse, at edge N+DEBOUNCE+2. The register acts on the pulse at edge N+DEBOUNCE+3.
- A dir change takes DEBOUNCE+2 edges to reach cond. serialout selection follows cond dir in the same cycle.
- switch0 data is taken from cond at the shift edge; changes still in debounce are not used.
- One shift per conditioned rising edge of switch1, regardless of how long switch1 is held.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE=4, parallelin=8'hA5 and a 20 ns clock.
- Reset, then idle 20 cycles -> parallelout 8'h00, serialout 0, shiftcount 0, done 0.
- Pulse btn0 high for 10 cycles -> parallelout 8'hA5 exactly 7 edges after first sample. serialout 1, shiftcount 0.
- Load A5; switch0=0, dir=0; raise switch1 -> parallelout 8'h4A, serialout 0, shiftcount 1. Holding switch1 does not shift again.
- Load A5; switch0=1, dir=1 (settled); one switch1 rising edge -> parallelout 8'hD2, serialout 0 (LSB).
- switch1 glitch of 3 cycles -> no shift and shiftcount unchanged. A 4-cycle glitch -> exactly one shift.
- Load A5; switch0=1, dir=0; 9 switch1 edges -> parallelout 8'hFF after the 8th, with done=1 and shiftcount 8. The 9th edge keeps 8'hFF and done=1. A load pulse in the same cycle as a shift pulse -> 8'hA5, shiftcount 0, done 0. Reset asserted mid-debounce -> no action after release.

Source files
------------

// File: rtl/shiftreg_controller_if.sv
// Bus bundle for shiftreg_controller: raw board inputs, parallel load data
// and the register/status outputs, plus the reserved edge-pulse taps.
interface shiftreg_controller_if #(
  parameter int WIDTH = 8
);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic             btn0;
  logic             switch0;
  logic             switch1;
  logic             dir;
  logic [WIDTH-1:0] parallelin;
  logic [WIDTH-1:0] parallelout;
  logic             serialout;
  logic [CNTW-1:0]  shiftcount;
  logic             done;
  // Conditioned edge pulses, bit order {dir, switch1, switch0, btn0}.
  logic [3:0]       pulse_pos;
  logic [3:0]       pulse_neg;

  modport master (
    output btn0, switch0, switch1, dir, parallelin,
    input  parallelout, serialout, shiftcount, done, pulse_pos, pulse_neg
  );

  modport slave (
    input  btn0, switch0, switch1, dir, parallelin,
    output parallelout, serialout, shiftcount, done, pulse_pos, pulse_neg
  );
endinterface

// File: rtl/shiftreg_controller.sv
// Button/switch conditioned WIDTH-bit shift register with parallel load,
// bidirectional serial shift and a saturating shift counter.
module shiftreg_controller #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  shiftreg_controller_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int DBW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int NIN  = 4;
  localparam int IDX_BTN0 = 0;
  localparam int IDX_SW0  = 1;
  localparam int IDX_SW1  = 2;
  localparam int IDX_DIR  = 3;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] cond;
  logic [NIN-1:0] pos;
  logic [NIN-1:0] neg;

  assign raw = {bus.dir, bus.switch1, bus.switch0, bus.btn0};

  // One conditioner per raw input: input capture flop, 2-FF synchroniser,
  // then a debounce counter that only commits a level after DEBOUNCE
  // consecutive disagreeing synchronised cycles. The capture flop gives
  // the raw-sample-to-cond latency of DEBOUNCE+2 edges.
  for (genvar gi = 0; gi < NIN; gi++) begin : g_cond
    logic           cap_q;
    logic           sync1_q;
    logic           sync2_q;
    logic           cond_q, cond_d;
    logic           pos_q, pos_d;
    logic           neg_q, neg_d;
    logic [DBW-1:0] cnt_q, cnt_d;

    // Debounce decision: any agreement clears the count and aborts a change.
    always_comb begin
      cnt_d  = cnt_q;
      cond_d = cond_q;
      pos_d  = 1'b0;
      neg_d  = 1'b0;
      if (sync2_q == cond_q) begin
        cnt_d = '0;
      end else if (cnt_q == DBW'(DEBOUNCE - 1)) begin
        cond_d = sync2_q;
        cnt_d  = '0;
        pos_d  = sync2_q;
        neg_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + DBW'(1);
      end
    end

    // Conditioner state; reset discards any partial debounce count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cap_q   <= 1'b0;
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cond_q  <= 1'b0;
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        cap_q   <= raw[gi];
        sync1_q <= cap_q;
        sync2_q <= sync1_q;
        cond_q  <= cond_d;
        pos_q   <= pos_d;
        neg_q   <= neg_d;
        cnt_q   <= cnt_d;
      end
    end

    assign cond[gi] = cond_q;
    assign pos[gi]  = pos_q;
    assign neg[gi]  = neg_q;
  end

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNTW-1:0]  scnt_q, scnt_d;
  logic             load_pulse;
  logic             shift_pulse;
  logic             dir_c;
  logic             sdata_c;

  assign load_pulse  = pos[IDX_BTN0];
  assign shift_pulse = pos[IDX_SW1];
  assign dir_c       = cond[IDX_DIR];
  assign sdata_c     = cond[IDX_SW0];

  // Register action: load beats shift; shift count saturates at WIDTH.
  always_comb begin
    sreg_d = sreg_q;
    scnt_d = scnt_q;
    if (load_pulse) begin
      sreg_d = bus.parallelin;
      scnt_d = '0;
    end else if (shift_pulse) begin
      if (!dir_c) begin
        sreg_d = {sreg_q[WIDTH-2:0], sdata_c};
      end else begin
        sreg_d = {sdata_c, sreg_q[WIDTH-1:1]};
      end
      if (scnt_q != CNTW'(WIDTH)) begin
        scnt_d = scnt_q + CNTW'(1);
      end
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      scnt_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      scnt_q <= scnt_d;
    end
  end

  assign bus.parallelout = sreg_q;
  assign bus.shiftcount  = scnt_q;
  assign bus.serialout   = dir_c ? sreg_q[0] : sreg_q[WIDTH-1];
  assign bus.done        = (scnt_q == CNTW'(WIDTH));
  assign bus.pulse_pos   = pos;
  assign bus.pulse_neg   = neg;
endmodule

// File: tb/tb_shiftreg_controller.sv
// Scoreboard bench for shiftreg_controller (WIDTH=8, DEBOUNCE=4, 20 ns clock).
module tb_shiftreg_controller;
  localparam int WIDTH    = 8;
  localparam int DEBOUNCE = 4;
  localparam int CNTW     = $clog2(WIDTH + 1);
  localparam int SETTLE   = 12;

  logic clk = 1'b0;
  logic reset;

  shiftreg_controller_if #(.WIDTH(WIDTH)) bus_if ();

  shiftreg_controller #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef logic [WIDTH+CNTW-1:0] snap_t;
  snap_t exp_q[$];
  snap_t obs_q[$];
  snap_t prev = '0;
  snap_t e, o;

  // Reference model of the register, updated as stimulus is driven.
  logic [WIDTH-1:0] m_reg = '0;
  logic [CNTW-1:0]  m_cnt = '0;
  logic             m_dir = 1'b0;
  logic             m_sw0 = 1'b0;

  // Monitor: log every change of {parallelout, shiftcount} after the edge.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      prev = '0;
    end else if ({bus_if.parallelout, bus_if.shiftcount} !== prev) begin
      prev = {bus_if.parallelout, bus_if.shiftcount};
      obs_q.push_back(prev);
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_if_changed(input logic [WIDTH-1:0] r, input logic [CNTW-1:0] c);
    if (r !== m_reg || c !== m_cnt) exp_q.push_back({r, c});
    m_reg = r;
    m_cnt = c;
  endtask

  task automatic do_load();
    push_if_changed(8'hA5, '0);
    bus_if.btn0 = 1'b1;
    hold(SETTLE);
    bus_if.btn0 = 1'b0;
    hold(SETTLE);
  endtask

  task automatic do_shift();
    logic [WIDTH-1:0] r;
    logic [CNTW-1:0]  c;
    r = m_dir ? {m_sw0, m_reg[WIDTH-1:1]} : {m_reg[WIDTH-2:0], m_sw0};
    c = (m_cnt == CNTW'(WIDTH)) ? m_cnt : m_cnt + CNTW'(1);
    push_if_changed(r, c);
    bus_if.switch1 = 1'b1;
    hold(SETTLE);
    bus_if.switch1 = 1'b0;
    hold(SETTLE);
  endtask

  task automatic set_dir_sw0(input logic d, input logic s);
    bus_if.dir     = d;
    bus_if.switch0 = s;
    m_dir = d;
    m_sw0 = s;
    hold(SETTLE);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(20);
    total++; if (bus_if.parallelout !== 8'h00) begin bad++; $display("FAIL reset_po: got %h want 00", bus_if.parallelout); end
    total++; if (bus_if.serialout !== 1'b0) begin bad++; $display("FAIL reset_so: got %b want 0", bus_if.serialout); end
    total++; if (bus_if.shiftcount !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus_if.shiftcount); end
    total++; if (bus_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reset_idle: got %0d changes want 0", obs_q.size()); obs_q.delete(); end
    $display("txn reset: po=%h cnt=%0d", bus_if.parallelout, bus_if.shiftcount);
  endtask

  task automatic test_load();
    push_if_changed(8'hA5, '0);
    bus_if.btn0 = 1'b1;        // first sampled at the next rising edge
    hold(7);                   // edges N..N+6 passed
    total++; if (bus_if.parallelout !== 8'h00) begin bad++; $display("FAIL load_early: got %h want 00", bus_if.parallelout); end
    hold(1);                   // edge N+7 passed
    total++; if (bus_if.parallelout !== 8'hA5) begin bad++; $display("FAIL load_latency: got %h want a5", bus_if.parallelout); end
    hold(2);
    bus_if.btn0 = 1'b0;
    hold(SETTLE);
    total++; if (bus_if.serialout !== 1'b1) begin bad++; $display("FAIL load_so: got %b want 1", bus_if.serialout); end
    total++; if (bus_if.shiftcount !== '0) begin bad++; $display("FAIL load_cnt: got %0d want 0", bus_if.shiftcount); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL load_sb: got nothing want %h", e); end
      else begin
        o = obs_q.pop_front();
        $display("txn load: obs=%h exp=%h", o, e);
        if (o !== e) begin bad++; $display("FAIL load_sb: got %h want %h", o, e); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL load_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_shift_left();
    set_dir_sw0(1'b0, 1'b0);
    push_if_changed(8'h4A, CNTW'(1));
    bus_if.switch1 = 1'b1;
    hold(3 * SETTLE);          // held long: must still be a single shift
    total++; if (bus_if.parallelout !== 8'h4A) begin bad++; $display("FAIL left_po: got %h want 4a", bus_if.parallelout); end
    total++; if (bus_if.serialout !== 1'b0) begin bad++; $display("FAIL left_so: got %b want 0", bus_if.serialout); end
    total++; if (bus_if.shiftcount !== CNTW'(1)) begin bad++; $display("FAIL left_cnt: got %0d want 1", bus_if.shiftcount); end
    bus_if.switch1 = 1'b0;
    hold(SETTLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL left_sb: got nothing want %h", e); end
      else begin
        o = obs_q.pop_front();
        $display("txn shift_left: obs=%h exp=%h", o, e);
        if (o !== e) begin bad++; $display("FAIL left_sb: got %h want %h", o, e); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL left_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_shift_right();
    do_load();
    set_dir_sw0(1'b1, 1'b1);
    total++; if (bus_if.serialout !== 1'b1) begin bad++; $display("FAIL right_so_pre: got %b want 1", bus_if.serialout); end
    do_shift();
    total++; if (bus_if.parallelout !== 8'hD2) begin bad++; $display("FAIL right_po: got %h want d2", bus_if.parallelout); end
    total++; if (bus_if.serialout !== 1'b0) begin bad++; $display("FAIL right_so: got %b want 0", bus_if.serialout); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL right_sb: got nothing want %h", e); end
      else begin
        o = obs_q.pop_front();
        $display("txn shift_right: obs=%h exp=%h", o, e);
        if (o !== e) begin bad++; $display("FAIL right_sb: got %h want %h", o, e); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL right_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_glitch();
    logic [WIDTH-1:0] r;
    bus_if.switch1 = 1'b1;
    hold(DEBOUNCE - 1);
    bus_if.switch1 = 1'b0;
    hold(SETTLE);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL glitch3_change: got %0d changes want 0", obs_q.size()); obs_q.delete(); end
    total++; if (bus_if.shiftcount !== m_cnt) begin bad++; $display("FAIL glitch3_cnt: got %0d want %0d", bus_if.shiftcount, m_cnt); end
    $display("txn glitch3: cnt=%0d", bus_if.shiftcount);
    r = {m_sw0, m_reg[WIDTH-1:1]};
    push_if_changed(r, m_cnt + CNTW'(1));
    bus_if.switch1 = 1'b1;
    hold(DEBOUNCE);
    bus_if.switch1 = 1'b0;
    hold(SETTLE + DEBOUNCE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL glitch4_sb: got nothing want %h", e); end
      else begin
        o = obs_q.pop_front();
        $display("txn glitch4: obs=%h exp=%h", o, e);
        if (o !== e) begin bad++; $display("FAIL glitch4_sb: got %h want %h", o, e); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL glitch4_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_saturate();
    set_dir_sw0(1'b0, 1'b1);
    do_load();
    for (int i = 0; i < WIDTH + 1; i++) begin
      do_shift();
      if (i >= WIDTH - 1) begin
        total++; if (bus_if.parallelout !== 8'hFF) begin bad++; $display("FAIL sat_po%0d: got %h want ff", i + 1, bus_if.parallelout); end
        total++; if (bus_if.shiftcount !== CNTW'(WIDTH)) begin bad++; $display("FAIL sat_cnt%0d: got %0d want 8", i + 1, bus_if.shiftcount); end
        total++; if (bus_if.done !== 1'b1) begin bad++; $display("FAIL sat_done%0d: got %b want 1", i + 1, bus_if.done); end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL sat_sb: got nothing want %h", e); end
      else begin
        o = obs_q.pop_front();
        $display("txn saturate: obs=%h exp=%h", o, e);
        if (o !== e) begin bad++; $display("FAIL sat_sb: got %h want %h", o, e); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL sat_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_load_vs_shift();
    push_if_changed(8'hA5, '0);
    bus_if.btn0    = 1'b1;
    bus_if.switch1 = 1'b1;
    hold(SETTLE);
    bus_if.btn0    = 1'b0;
    bus_if.switch1 = 1'b0;
    hold(SETTLE);
    total++; if (bus_if.parallelout !== 8'hA5) begin bad++; $display("FAIL both_po: got %h want a5", bus_if.parallelout); end
    total++; if (bus_if.shiftcount !== '0) begin bad++; $display("FAIL both_cnt: got %0d want 0", bus_if.shiftcount); end
    total++; if (bus_if.done !== 1'b0) begin bad++; $display("FAIL both_done: got %b want 0", bus_if.done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL both_sb: got nothing want %h", e); end
      else begin
        o = obs_q.pop_front();
        $display("txn load_vs_shift: obs=%h exp=%h", o, e);
        if (o !== e) begin bad++; $display("FAIL both_sb: got %h want %h", o, e); end
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL both_extra: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bus_if.switch1 = 1'b1;
    hold(DEBOUNCE);            // debounce count in progress
    reset = 1'b1;
    hold(2);
    bus_if.switch1 = 1'b0;
    hold(1);
    reset = 1'b0;
    m_reg = '0;
    m_cnt = '0;
    hold(SETTLE + 3);
    total++; if (bus_if.parallelout !== 8'h00) begin bad++; $display("FAIL rstmid_po: got %h want 00", bus_if.parallelout); end
    total++; if (bus_if.shiftcount !== '0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", bus_if.shiftcount); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_action: got %0d changes want 0", obs_q.size()); obs_q.delete(); end
    $display("txn reset_mid: po=%h cnt=%0d", bus_if.parallelout, bus_if.shiftcount);
  endtask

  initial begin
    reset             = 1'b1;
    bus_if.btn0       = 1'b0;
    bus_if.switch0    = 1'b0;
    bus_if.switch1    = 1'b0;
    bus_if.dir        = 1'b0;
    bus_if.parallelin = 8'hA5;
    hold(1);
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_glitch();
    test_saturate();
    test_load_vs_shift();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
